// File: rtl/dram_wbuf.sv
// Posted-write buffer between the DRAM arbiter and the DRAM controller: a small
// FIFO of writes drained in order, with one read held until the writes ahead of it reach DRAM.
// Optional read forwarding from buffered full-word writes: define DRAM_WBUF_FORWARD_EN.
module dram_wbuf #(
  parameter int MEM_SCALE = 27,
  parameter int DEPTH_LOG = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_oe,
  input  logic [MEM_SCALE-1:0] up_addr,
  input  logic [31:0]          up_wdata,
  input  logic [3:0]           up_we,
  output logic [31:0]          up_rdata,
  output logic                 up_valid,
  output logic                 up_written,
  output logic                 up_busy,
  output logic                 dn_oe,
  output logic [MEM_SCALE-1:0] dn_addr,
  output logic [31:0]          dn_wdata,
  output logic [3:0]           dn_we,
  input  logic [31:0]          dn_rdata,
  input  logic                 dn_valid,
  input  logic                 dn_written
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT} state_t;

  state_t state_q, state_d;

  logic [MEM_SCALE-1:0] addrMem_q [DEPTH];
  logic [31:0]          dataMem_q [DEPTH];
  logic [3:0]           weMem_q   [DEPTH];
  logic [DEPTH_LOG:0]   wptr_q, rptr_q;

  logic                 rdPend_q;
  logic [MEM_SCALE-1:0] rdAddr_q;
  logic                 upWritten_q, upValid_q;
  logic [31:0]          upRdata_q;
  logic                 dnOe_q;
  logic [MEM_SCALE-1:0] dnAddr_q;
  logic [31:0]          dnWdata_q;
  logic [3:0]           dnWe_q;

  logic                 full, empty, busy;
  logic                 acceptWr, acceptRd;
  logic [MEM_SCALE-1:0] wordAddr;
  logic                 issueWr, issueRd, pop, rdDone;
  logic                 fwdHit;
  logic [31:0]          fwdData;

  assign full  = (wptr_q[DEPTH_LOG] != rptr_q[DEPTH_LOG]) &&
                 (wptr_q[DEPTH_LOG-1:0] == rptr_q[DEPTH_LOG-1:0]);
  assign empty = (wptr_q == rptr_q);
  // Busy depends only on registered state so the arbiter never sees a loop through up_oe.
  assign busy  = full | rdPend_q;

  assign wordAddr = up_addr & ~MEM_SCALE'(3);
  assign acceptWr = up_oe & ~busy & (up_we != 4'h0);
  assign acceptRd = up_oe & ~busy & (up_we == 4'h0);

`ifdef DRAM_WBUF_FORWARD_EN
  logic [DEPTH_LOG:0] occ;

  // Walk oldest to youngest so the youngest matching entry decides the outcome.
  always_comb begin
    fwdHit  = 1'b0;
    fwdData = '0;
    occ     = wptr_q - rptr_q;
    for (int k = 0; k < DEPTH; k++) begin
      if (((DEPTH_LOG+1)'(k) < occ) &&
          (addrMem_q[rptr_q[DEPTH_LOG-1:0] + DEPTH_LOG'(k)] == wordAddr)) begin
        fwdHit  = (weMem_q[rptr_q[DEPTH_LOG-1:0] + DEPTH_LOG'(k)] == 4'hF);
        fwdData = dataMem_q[rptr_q[DEPTH_LOG-1:0] + DEPTH_LOG'(k)];
      end
    end
  end
`else
  assign fwdHit  = 1'b0;
  assign fwdData = '0;
`endif

  always_comb begin
    state_d = state_q;
    issueWr = 1'b0;
    issueRd = 1'b0;
    pop     = 1'b0;
    rdDone  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          issueWr = 1'b1;
          state_d = WR_WAIT;
        end else if (rdPend_q) begin
          issueRd = 1'b1;
          state_d = RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (dn_written) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (dn_valid) begin
          rdDone  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rdPend_q    <= 1'b0;
      rdAddr_q    <= '0;
      upWritten_q <= 1'b0;
      upValid_q   <= 1'b0;
      upRdata_q   <= '0;
      dnOe_q      <= 1'b0;
      dnAddr_q    <= '0;
      dnWdata_q   <= '0;
      dnWe_q      <= '0;
    end else begin
      state_q     <= state_d;
      upWritten_q <= acceptWr;
      upValid_q   <= rdDone | (acceptRd & fwdHit);
      dnOe_q      <= issueWr | issueRd;
      if (acceptWr) wptr_q <= wptr_q + PTR_ONE;
      if (pop)      rptr_q <= rptr_q + PTR_ONE;
      if (rdDone) begin
        upRdata_q <= dn_rdata;
      end else if (acceptRd & fwdHit) begin
        upRdata_q <= fwdData;
      end
      if (acceptRd & ~fwdHit) begin
        rdPend_q <= 1'b1;
        rdAddr_q <= wordAddr;
      end else if (rdDone) begin
        rdPend_q <= 1'b0;
      end
      // Request fields are loaded only at issue, so they hold until the response.
      if (issueWr) begin
        dnAddr_q  <= addrMem_q[rptr_q[DEPTH_LOG-1:0]];
        dnWdata_q <= dataMem_q[rptr_q[DEPTH_LOG-1:0]];
        dnWe_q    <= weMem_q[rptr_q[DEPTH_LOG-1:0]];
      end else if (issueRd) begin
        dnAddr_q  <= rdAddr_q;
        dnWdata_q <= '0;
        dnWe_q    <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (acceptWr) begin
      addrMem_q[wptr_q[DEPTH_LOG-1:0]] <= wordAddr;
      dataMem_q[wptr_q[DEPTH_LOG-1:0]] <= up_wdata;
      weMem_q[wptr_q[DEPTH_LOG-1:0]]   <= up_we;
    end
  end

  assign up_rdata   = upRdata_q;
  assign up_valid   = upValid_q;
  assign up_written = upWritten_q;
  assign up_busy    = busy;
  assign dn_oe      = dnOe_q;
  assign dn_addr    = dnAddr_q;
  assign dn_wdata   = dnWdata_q;
  assign dn_we      = dnWe_q;

endmodule

// File: tb/tb_dram_wbuf.sv
// Self-checking bench for dram_wbuf: a queue-based model of the write buffer and a
// small DRAM memory model; build with DRAM_WBUF_FORWARD_EN to exercise forwarding.
`timescale 1ns/1ps
module tb_dram_wbuf;

  localparam int AW = 27;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_oe;
  logic [AW-1:0] up_addr;
  logic [31:0]   up_wdata;
  logic [3:0]    up_we;
  logic [31:0]   up_rdata;
  logic          up_valid, up_written, up_busy;
  logic          dn_oe;
  logic [AW-1:0] dn_addr;
  logic [31:0]   dn_wdata;
  logic [3:0]    dn_we;
  logic [31:0]   dn_rdata;
  logic          dn_valid, dn_written;

  always #5 clk = ~clk;

  dram_wbuf #(.MEM_SCALE(AW), .DEPTH_LOG(2)) dut (
    .clk(clk), .rst(rst),
    .up_oe(up_oe), .up_addr(up_addr), .up_wdata(up_wdata), .up_we(up_we),
    .up_rdata(up_rdata), .up_valid(up_valid), .up_written(up_written), .up_busy(up_busy),
    .dn_oe(dn_oe), .dn_addr(dn_addr), .dn_wdata(dn_wdata), .dn_we(dn_we),
    .dn_rdata(dn_rdata), .dn_valid(dn_valid), .dn_written(dn_written)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    we;
  } entry_t;

  // Model: buffered writes in order, the architectural memory the arbiter expects,
  // and the memory the DRAM actually holds.
  entry_t        mq[$];
  logic [31:0]   archMem [int];
  logic [31:0]   dramMem [int];
  bit            rdPend;
  logic [AW-1:0] rdAddrM;
  logic [31:0]   rdExpM;
  int            outKind;
  entry_t        outTxn;
  int            outLat;
  bit            expWritten, expValid;
  logic [31:0]   expRdata;

  bit stall, forceResp, injectValid, spurEn;
  int fixLat, idleGap, cycleNo;
  int nChecks, nFails;
  int writtenPulses, validPulses, dnWrCount, dnRdCount;
  int lastWrStamp, lastRdStamp;
  logic [31:0]   lastRdata, sampledRdata;
  logic [AW-1:0] lastDnAddr;
  logic [31:0]   lastDnWdata;
  logic [3:0]    lastDnWe;
  bit            lastBusy;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] we);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic bit modelBusy();
    return (mq.size() == 4) || rdPend;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  // One clock cycle: check outputs at the falling edge, play the DRAM, drive the arbiter
  // side, then advance the model to what the next rising edge must produce.
  task automatic applyStimulus(input bit oe, input logic [AW-1:0] addr,
                               input logic [31:0] wd, input logic [3:0] we);
    bit busyNow, respW, respR, fwd, nW, nV;
    logic [AW-1:0] waddr;
    logic [31:0] nD;
    @(negedge clk);
    cycleNo++;
    busyNow = modelBusy();
    checkOutput("up_written", up_written, expWritten);
    checkOutput("up_valid", up_valid, expValid);
    if (expValid) checkOutput("up_rdata", up_rdata, expRdata);
    checkOutput("up_busy", up_busy, busyNow);
    lastBusy = up_busy;
    sampledRdata = up_rdata;
    if (up_written) writtenPulses++;
    if (up_valid) begin validPulses++; lastRdata = up_rdata; end

    if (dn_oe) begin
      lastDnAddr = dn_addr; lastDnWdata = dn_wdata; lastDnWe = dn_we;
      if (outKind != 0) begin
        checkOutput("dn_oe_overlap", outKind, 0);
      end else if (mq.size() > 0) begin
        checkOutput("dn_addr_wr", dn_addr, mq[0].addr);
        checkOutput("dn_wdata_wr", dn_wdata, mq[0].data);
        checkOutput("dn_we_wr", dn_we, mq[0].we);
        outKind = 1; outTxn = mq[0]; dnWrCount++; lastWrStamp = cycleNo;
      end else if (rdPend) begin
        checkOutput("dn_addr_rd", dn_addr, rdAddrM);
        checkOutput("dn_we_rd", dn_we, 4'h0);
        outKind = 2; outTxn = '{rdAddrM, 32'h0, 4'h0}; dnRdCount++; lastRdStamp = cycleNo;
      end else begin
        checkOutput("dn_oe_unexpected", dn_oe, 1'b0);
      end
      outLat = (fixLat != 0) ? fixLat : int'($urandom_range(2, 5));
      idleGap = 0;
    end else if (outKind != 0) begin
      checkOutput("dn_addr_hold", dn_addr, outTxn.addr);
      checkOutput("dn_we_hold", dn_we, outTxn.we);
      if (outKind == 1) checkOutput("dn_wdata_hold", dn_wdata, outTxn.data);
    end else if (mq.size() > 0 || rdPend) begin
      idleGap++;
      if (idleGap > 3) begin
        checkOutput("dn_oe_missing", dn_oe, 1'b1);
        idleGap = 0;
      end
    end

    dn_valid = 1'b0; dn_written = 1'b0; dn_rdata = $urandom;
    respW = 1'b0; respR = 1'b0;
    if (outKind != 0) begin
      if (outLat > 0) outLat--;
      if (forceResp || (!stall && outLat == 0)) begin
        if (outKind == 1) begin
          dn_written = 1'b1; respW = 1'b1;
        end else begin
          dn_valid = 1'b1; dn_rdata = dramMem[int'(outTxn.addr)]; respR = 1'b1;
        end
      end else if (spurEn && $urandom_range(0, 7) == 0) begin
        if (outKind == 1) dn_valid = 1'b1; else dn_written = 1'b1;
      end
    end else if (injectValid) begin
      dn_valid = 1'b1;
    end else if (spurEn && $urandom_range(0, 7) == 0) begin
      if ($urandom_range(0, 1) == 1) dn_valid = 1'b1; else dn_written = 1'b1;
    end

    up_oe = oe; up_addr = addr; up_wdata = wd; up_we = we;
    nW = 1'b0; nV = 1'b0; nD = '0;
    if (oe && !busyNow) begin
      waddr = {addr[AW-1:2], 2'b00};
      if (we != 4'h0) begin
        mq.push_back('{waddr, wd, we});
        archMem[int'(waddr)] = merge(archMem[int'(waddr)], wd, we);
        nW = 1'b1;
      end else begin
        fwd = 1'b0;
`ifdef DRAM_WBUF_FORWARD_EN
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if (mq[i].addr == waddr) begin
            if (mq[i].we == 4'hF) begin fwd = 1'b1; nD = mq[i].data; end
            break;
          end
        end
`endif
        if (fwd) nV = 1'b1;
        else begin rdPend = 1'b1; rdAddrM = waddr; rdExpM = archMem[int'(waddr)]; end
      end
    end

    if (respW) begin
      dramMem[int'(outTxn.addr)] = merge(dramMem[int'(outTxn.addr)], outTxn.data, outTxn.we);
      void'(mq.pop_front());
      outKind = 0;
    end
    if (respR) begin
      nV = 1'b1; nD = rdExpM; rdPend = 1'b0; outKind = 0;
    end

    @(posedge clk);
    expWritten = nW; expValid = nV; expRdata = nD;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, '0, '0, 4'h0);
  endtask

  task automatic drain();
    for (int c = 0; c < 100; c++) begin
      if (mq.size() == 0 && outKind == 0 && !rdPend && !expValid) break;
      idle(1);
    end
    checkOutput("drain_done", mq.size(), 0);
  endtask

  task automatic waitValid(input int v0);
    for (int c = 0; c < 60 && validPulses == v0; c++) idle(1);
    checkOutput("valid_seen", validPulses - v0, 1);
  endtask

  task automatic doReset();
    rst = 1'b1; up_oe = 1'b0; dn_valid = 1'b0; dn_written = 1'b0; dn_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_up_valid", up_valid, 1'b0);
    checkOutput("rst_up_written", up_written, 1'b0);
    checkOutput("rst_up_busy", up_busy, 1'b0);
    checkOutput("rst_dn_oe", dn_oe, 1'b0);
    checkOutput("rst_up_rdata", up_rdata, 32'h0);
    checkOutput("rst_dn_addr", dn_addr, '0);
    checkOutput("rst_dn_wdata", dn_wdata, 32'h0);
    checkOutput("rst_dn_we", dn_we, 4'h0);
    rst = 1'b0;
    mq.delete(); rdPend = 1'b0; outKind = 0; idleGap = 0;
    expWritten = 1'b0; expValid = 1'b0; expRdata = '0;
    archMem = dramMem;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int w0, d0, v0, r0, acc;
    nChecks = 0; nFails = 0; cycleNo = 0;
    writtenPulses = 0; validPulses = 0; dnWrCount = 0; dnRdCount = 0;
    lastWrStamp = 0; lastRdStamp = 0;
    stall = 0; forceResp = 0; injectValid = 0; spurEn = 0; fixLat = 0;
    up_oe = 0; up_addr = '0; up_wdata = '0; up_we = '0;
    dn_rdata = '0; dn_valid = 0; dn_written = 0;
    for (int a = 'h100; a < 'h120; a += 4) dramMem[a] = 32'hA5000000 | a;
    dramMem['h200] = 32'h0BADF00D;
    dramMem['h300] = 32'h11223344;
    archMem = dramMem;
    doReset();

    // Single write, DRAM answering after three cycles.
    fixLat = 3; w0 = writtenPulses; d0 = dnWrCount;
    applyStimulus(1'b1, 'h100, 32'hDEADBEEF, 4'hF);
    idle(1);
    checkOutput("single_written", writtenPulses - w0, 1);
    idle(10);
    checkOutput("single_dn_count", dnWrCount - d0, 1);
    checkOutput("single_dn_addr", lastDnAddr, 'h100);
    checkOutput("single_dn_we", lastDnWe, 4'hF);
    checkOutput("single_dn_wdata", lastDnWdata, 32'hDEADBEEF);
    fixLat = 0;

    // Five writes against a stalled DRAM: the fifth meets a full buffer.
    stall = 1; w0 = writtenPulses;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, AW'('h100 + 4*i), 32'h50000000 + i, 4'hF);
    idle(1);
    checkOutput("full_written", writtenPulses - w0, 4);
    checkOutput("full_busy", lastBusy, 1'b1);

    // Pop and a write attempt in the same cycle while full: write refused.
    forceResp = 1; w0 = writtenPulses;
    applyStimulus(1'b1, 'h114, 32'hBADBAD00, 4'hF);
    forceResp = 0;
    idle(1);
    checkOutput("full_pop_ignored", writtenPulses - w0, 0);
    checkOutput("full_pop_not_busy", lastBusy, 1'b0);

    // Ten more writes walk the pointers past their wrap point.
    stall = 0; acc = 0; w0 = writtenPulses;
    for (int c = 0; c < 300 && acc < 10; c++) begin
      if (!modelBusy()) begin
        applyStimulus(1'b1, AW'('h100 + 4*(c % 4)), $urandom, 4'hF);
        acc++;
      end else idle(1);
    end
    drain();
    checkOutput("wrap_written", writtenPulses - w0, 10);

    // Write then read of the same word.
    v0 = validPulses; r0 = dnRdCount;
    applyStimulus(1'b1, 'h200, 32'h12345678, 4'hF);
    applyStimulus(1'b1, 'h200, 32'h0, 4'h0);
`ifdef DRAM_WBUF_FORWARD_EN
    idle(1);
    checkOutput("fwd_valid_next", validPulses - v0, 1);
    checkOutput("fwd_data", lastRdata, 32'h12345678);
    drain();
    checkOutput("fwd_no_dram_read", dnRdCount - r0, 0);
`else
    waitValid(v0);
    checkOutput("rar_data", lastRdata, 32'h12345678);
    checkOutput("rar_dram_read", dnRdCount - r0, 1);
    checkOutput("rar_write_first", lastWrStamp < lastRdStamp, 1'b1);
    drain();
`endif

    // Partial-word write followed by a read must go through DRAM.
    v0 = validPulses; r0 = dnRdCount;
    applyStimulus(1'b1, 'h300, 32'hAABBCCDD, 4'h3);
    applyStimulus(1'b1, 'h302, 32'h0, 4'h0);
    waitValid(v0);
    checkOutput("partial_data", lastRdata, 32'h1122CCDD);
    checkOutput("partial_dram_read", dnRdCount - r0, 1);
    drain();

    // Randomized traffic with stall windows and stray DRAM pulses.
    spurEn = 1;
    for (int c = 0; c < 400; c++) begin
      logic [AW-1:0] a;
      logic [3:0] w;
      bit o;
      o = ($urandom_range(0, 9) < 6);
      a = AW'(32'h100 + 4*$urandom_range(0, 3) + $urandom_range(0, 3));
      if ($urandom_range(0, 9) < 3) w = 4'h0;
      else if ($urandom_range(0, 1) == 1) w = 4'hF;
      else w = 4'($urandom_range(1, 15));
      stall = ((c % 80) >= 60);
      applyStimulus(o, a, $urandom, w);
    end
    stall = 0; spurEn = 0;
    drain();

    // Reset while a read waits on DRAM, then a late response.
    stall = 1; r0 = dnRdCount;
    applyStimulus(1'b1, 'h104, 32'h0, 4'h0);
    for (int c = 0; c < 10 && dnRdCount == r0; c++) idle(1);
    checkOutput("rst_rd_issued", dnRdCount - r0, 1);
    idle(2);
    doReset();
    stall = 0; v0 = validPulses;
    injectValid = 1; idle(1); injectValid = 0;
    idle(3);
    checkOutput("late_valid_ignored", validPulses - v0, 0);
    checkOutput("late_rdata_zero", sampledRdata, 32'h0);
    d0 = dnWrCount;
    applyStimulus(1'b1, 'h108, 32'hCAFEF00D, 4'hF);
    drain();
    checkOutput("post_rst_write", dnWrCount - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
